// File: rtl/io_seq_pkg.sv
// Shared definitions for the blocking-instruction sequencer.
//   OP_INPUT / OP_OUTPUT / OP_HALT : opcodes that stall the CPU for the operator
//   seq_state_t                    : FSM state encoding (fixed, visible on state_dbg)
//   is_blocking()                  : true for any of the three blocking opcodes
package io_seq_pkg;

  localparam logic [5:0] OP_INPUT  = 6'b000111;
  localparam logic [5:0] OP_OUTPUT = 6'b111000;
  localparam logic [5:0] OP_HALT   = 6'b111110;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IN   = 3'd1,
    ST_WAIT_OUT  = 3'd2,
    ST_WAIT_HALT = 3'd3,
    ST_RESUME_IN = 3'd4,
    ST_RESUME    = 3'd5
  } seq_state_t;

  function automatic logic is_blocking(input logic [5:0] op);
    return (op == OP_INPUT) || (op == OP_OUTPUT) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/io_halt_sequencer_debouncer.sv
// enter_debouncer: conditions the raw, bouncy enter push-button.
//   clock, reset : system clock, asynchronous active-high reset
//   enter        : raw asynchronous button input
//   press        : registered one-cycle pulse per debounced rising edge
module enter_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             enter_s;
  logic             enter_db;
  logic             enter_db_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      enter_s    <= 1'b0;
      enter_db   <= 1'b0;
      enter_db_d <= 1'b0;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      sync1      <= enter;
      enter_s    <= sync1;
      enter_db_d <= enter_db;
      // Rising edge of the debounced level only, so a held button yields one press.
      press      <= enter_db & ~enter_db_d;
      // Counter measures how long the synchronised input has disagreed with
      // the debounced level; any agreement restarts the measurement.
      if (enter_s != enter_db) begin
        if (cnt == CNT_LAST) begin
          enter_db <= ~enter_db;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/io_halt_sequencer.sv
// io_halt_sequencer: stalls the CPU on INPUT/OUTPUT/HALT until the operator
// presses enter, captures the switch bank, and latches the display value.
//   clock, reset     : system clock, asynchronous active-high reset
//   opcode           : opcode of the instruction in execute
//   instr_valid      : opcode is a real instruction this cycle
//   enter            : raw push-button
//   switches         : raw switch bank (captured on INPUT)
//   out_data         : value to display on OUTPUT
//   pc_stall         : hold PC, suppress writes
//   wb_enable        : one-cycle write of input_data to the destination register
//   input_data       : captured switches, zero-extended
//   display_data     : latched OUTPUT value
//   display_valid    : display_data written since reset
//   halted           : in HALT wait
//   state_dbg        : FSM state encoding
//
// state        | meaning
// -------------+---------------------------------------------------
// IDLE         | no blocking instruction pending; press is ignored
// WAIT_IN      | INPUT accepted, waiting for press to sample switches
// WAIT_OUT     | OUTPUT latched, waiting for operator acknowledge
// WAIT_HALT    | HALT, waiting for press to continue
// RESUME_IN    | release stall and write captured switches back
// RESUME       | release stall after OUTPUT/HALT
module io_halt_sequencer
  import io_seq_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic              instr_valid,
  input  logic              enter,
  input  logic [SW_W-1:0]   switches,
  input  logic [DATA_W-1:0] out_data,
  output logic              pc_stall,
  output logic              wb_enable,
  output logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] display_data,
  output logic              display_valid,
  output logic              halted,
  output logic [2:0]        state_dbg
);

  seq_state_t state, state_nxt;
  logic       press;
  logic       capture_in;
  logic       latch_out;

  enter_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock (clock),
    .reset (reset),
    .enter (enter),
    .press (press)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture_in = 1'b0;
    latch_out  = 1'b0;
    pc_stall   = 1'b0;
    wb_enable  = 1'b0;
    halted     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A press arriving in the accept cycle is dropped: the wait states
        // only react to presses that happen after they are entered.
        if (instr_valid) begin
          pc_stall = is_blocking(opcode);
          if (opcode == OP_INPUT) begin
            state_nxt = ST_WAIT_IN;
          end else if (opcode == OP_OUTPUT) begin
            latch_out = 1'b1;
            state_nxt = ST_WAIT_OUT;
          end else if (opcode == OP_HALT) begin
            state_nxt = ST_WAIT_HALT;
          end
        end
      end
      ST_WAIT_IN: begin
        pc_stall = 1'b1;
        if (press) begin
          capture_in = 1'b1;
          state_nxt  = ST_RESUME_IN;
        end
      end
      ST_WAIT_OUT: begin
        pc_stall = 1'b1;
        if (press) state_nxt = ST_RESUME;
      end
      ST_WAIT_HALT: begin
        pc_stall = 1'b1;
        halted   = 1'b1;
        if (press) state_nxt = ST_RESUME;
      end
      ST_RESUME_IN: begin
        wb_enable = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_RESUME: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Keep the stall low while reset is held even if a blocking opcode is
    // presented, so every output reads zero during reset.
    if (reset) pc_stall = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      input_data    <= '0;
      display_data  <= '0;
      display_valid <= 1'b0;
    end else begin
      if (capture_in) input_data <= DATA_W'(switches);
      if (latch_out) begin
        display_data  <= out_data;
        display_valid <= 1'b1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_io_halt_sequencer.sv
module tb_io_halt_sequencer;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int DB = 4;

  localparam logic [5:0] OPC_IN   = 6'b000111;
  localparam logic [5:0] OPC_OUT  = 6'b111000;
  localparam logic [5:0] OPC_HALT = 6'b111110;
  localparam logic [5:0] OPC_ADD  = 6'b100000;

  logic          clock = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          instr_valid;
  logic          enter;
  logic [SW-1:0] switches;
  logic [DW-1:0] out_data;
  logic          pc_stall;
  logic          wb_enable;
  logic [DW-1:0] input_data;
  logic [DW-1:0] display_data;
  logic          display_valid;
  logic          halted;
  logic [2:0]    state_dbg;

  io_halt_sequencer #(
    .DATA_W(DW), .SW_W(SW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
    .enter(enter), .switches(switches), .out_data(out_data),
    .pc_stall(pc_stall), .wb_enable(wb_enable), .input_data(input_data),
    .display_data(display_data), .display_valid(display_valid),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Modes: 0 idle, 1 wait-input, 2 wait-output, 3 halt,
  // 4 resume after input, 5 resume after output/halt.
  int          ms;
  logic [31:0] m_in, m_disp;
  logic        m_dv, m_press, m_db, m_db_d, e1, e2;
  logic        win[$];
  int          wb_count;

  task automatic model_reset();
    ms = 0; m_in = '0; m_disp = '0; m_dv = 0;
    m_press = 0; m_db = 0; m_db_d = 0; e1 = 0; e2 = 0;
    win.delete();
  endtask

  task automatic model_step();
    bit tog;
    case (ms)
      0: if (instr_valid) begin
           if (opcode == OPC_IN) ms = 1;
           else if (opcode == OPC_OUT) begin m_disp = out_data; m_dv = 1; ms = 2; end
           else if (opcode == OPC_HALT) ms = 3;
         end
      1: if (m_press) begin m_in = {16'h0, switches}; ms = 4; end
      2, 3: if (m_press) ms = 5;
      default: ms = 0;
    endcase
    // Debounced level flips once the last DB synchronised samples all disagree.
    win.push_back(e2);
    if (win.size() > DB) void'(win.pop_front());
    tog = 0;
    if (win.size() == DB) begin
      tog = 1;
      foreach (win[i]) if (win[i] == m_db) tog = 0;
    end
    m_press = m_db & ~m_db_d;
    m_db_d  = m_db;
    if (tog) begin m_db = ~m_db; win.delete(); end
    e2 = e1;
    e1 = enter;
  endtask

  task automatic cycle(input logic ev, input logic iv, input logic [5:0] op,
                       input logic [SW-1:0] sw, input logic [DW-1:0] od, input logic rs);
    logic exp_stall;
    @(negedge clock);
    enter = ev; instr_valid = iv; opcode = op; switches = sw; out_data = od;
    reset = rs;
    if (rs) model_reset();
    #1;
    exp_stall = !rs && ((ms == 0 && iv && (op == OPC_IN || op == OPC_OUT || op == OPC_HALT))
                        || ms == 1 || ms == 2 || ms == 3);
    chk("pc_stall", {31'b0, pc_stall}, {31'b0, exp_stall});
    chk("wb_enable", {31'b0, wb_enable}, {31'b0, ms == 4});
    chk("halted", {31'b0, halted}, {31'b0, ms == 3});
    chk("state_dbg", {29'b0, state_dbg}, ms);
    chk("input_data", input_data, m_in);
    chk("display_data", display_data, m_disp);
    chk("display_valid", {31'b0, display_valid}, {31'b0, m_dv});
    if (wb_enable) wb_count++;
    if (!rs) model_step();
  endtask

  task automatic idle_n(input int n, input logic ev);
    for (int i = 0; i < n; i++) cycle(ev, 1'b0, OPC_ADD, 16'h1234, 32'h5555_0000, 1'b0);
  endtask

  initial begin
    int burst;
    logic ev;
    logic [5:0] op;
    model_reset();
    wb_count = 0;
    enter = 0; instr_valid = 0; opcode = '0; switches = '0; out_data = '0; reset = 1;

    // Reset state.
    cycle(1'b0, 1'b0, OPC_ADD, 16'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, OPC_HALT, 16'h0, 32'h0, 1'b1);
    idle_n(2, 1'b0);

    // INPUT capture: hold enter 10 cycles, exactly one write-back.
    cycle(1'b0, 1'b1, OPC_IN, 16'h00A5, 32'h0, 1'b0);
    wb_count = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, OPC_IN, 16'h00A5, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, OPC_ADD, 16'h00A5, 32'h0, 1'b0);
    chk("input_a5", input_data, 32'h0000_00A5);
    chk("wb_pulses", wb_count, 1);

    // OUTPUT latch, value held after out_data changes.
    cycle(1'b0, 1'b1, OPC_OUT, 16'h0, 32'hDEAD_BEEF, 1'b0);
    idle_n(3, 1'b0);
    chk("display_hold", display_data, 32'hDEAD_BEEF);
    idle_n(8, 1'b1);
    idle_n(8, 1'b0);

    // Bounce rejection in HALT, then a real press.
    cycle(1'b0, 1'b1, OPC_HALT, 16'h0, 32'h0, 1'b0);
    idle_n(1, 1'b1); idle_n(2, 1'b0); idle_n(1, 1'b1); idle_n(8, 1'b0);
    chk("halt_after_bounce", {29'b0, state_dbg}, 3);
    idle_n(20, 1'b1);
    chk("halt_released", {31'b0, halted}, 0);
    idle_n(10, 1'b0);

    // Reset mid-wait with the button held through reset.
    cycle(1'b0, 1'b1, OPC_IN, 16'hFFFF, 32'h0, 1'b0);
    idle_n(3, 1'b1);
    cycle(1'b1, 1'b1, OPC_IN, 16'hFFFF, 32'h0, 1'b1);
    wb_count = 0;
    idle_n(15, 1'b1);
    chk("no_wb_after_reset", wb_count, 0);
    idle_n(10, 1'b0);

    // Randomized traffic.
    ev = 0; burst = 0;
    for (int i = 0; i < 4000; i++) begin
      if (burst == 0) begin
        ev = ~ev;
        burst = ev ? $urandom_range(1, 10) : $urandom_range(1, 14);
      end
      burst--;
      case ($urandom_range(0, 5))
        0: op = OPC_IN;
        1: op = OPC_OUT;
        2: op = OPC_HALT;
        3: op = OPC_ADD;
        default: op = 6'($urandom);
      endcase
      cycle(ev, $urandom_range(0, 3) != 0, op, 16'($urandom), $urandom,
            $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
